// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles the instruction-memory and data-memory handshake signals that the
//   sequencer exchanges with its memories.
//
//   Signals
//     instr      [31:0]  instruction word from instruction memory
//     imem_valid         instr is valid this cycle
//     imem_req           sequencer requests an instruction (FETCH)
//     dmem_ready         data memory completed the current access
//     dmem_rd            data memory read strobe (LOAD in MEM)
//     dmem_wr            data memory write strobe (STORE in MEM)
//
//   Modports
//     master : the sequencer side (drives the requests and strobes)
//     slave  : the memory side (drives instr/imem_valid/dmem_ready)
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
    logic [31:0] instr;
    logic        imem_valid;
    logic        imem_req;
    logic        dmem_ready;
    logic        dmem_rd;
    logic        dmem_wr;

    modport master (
        input  instr,
        input  imem_valid,
        input  dmem_ready,
        output imem_req,
        output dmem_rd,
        output dmem_wr
    );

    modport slave (
        output instr,
        output imem_valid,
        output dmem_ready,
        input  imem_req,
        input  dmem_rd,
        input  dmem_wr
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) ->
//   (WB) -> FETCH, with sticky HALT and FAULT states. Produces the datapath
//   control strobes for the held instruction register.
//
//   Parameters
//     MEM_TIMEOUT  max cycles spent in MEM waiting for dmem_ready (<= 32)
//     HALT_OPCODE  opcode that stops the sequencer
//
//   Ports
//     clk          clock, rising edge
//     reset_n      asynchronous active-low reset
//     bus          memory handshake interface (master side)
//     alu_zero     ALU zero flag, used in EXEC for BEQ/BNE
//     ir_load      load instr into ir (FETCH with imem_valid)
//     pc_inc       increment PC (FETCH with imem_valid)
//     pc_branch    take branch/jump (EXEC)
//     alu_src_imm  ALU second operand is the immediate (EXEC)
//     rf_we        register-file write enable (WB)
//     wb_sel       write-back source is memory (WB of LOAD)
//     halted       sequencer halted (sticky)
//     illegal      illegal opcode fault (sticky)
//     bus_err      data memory timeout fault (sticky)
//     alu_op       opcode of the held instruction
//     ir           held instruction register
//     state        current state, for debug
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [5:0] HALT_OPCODE = 6'd63
) (
    input  logic                      clk,
    input  logic                      reset_n,
    instr_sequencer_if.master         bus,
    input  logic                      alu_zero,
    output logic                      ir_load,
    output logic                      pc_inc,
    output logic                      pc_branch,
    output logic                      alu_src_imm,
    output logic                      rf_we,
    output logic                      wb_sel,
    output logic                      halted,
    output logic                      illegal,
    output logic                      bus_err,
    output logic [5:0]                alu_op,
    output logic [31:0]               ir,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RTYPE, C_ITYPE, C_LOAD, C_STORE,
        C_BEQ, C_BNE, C_JMP, C_HALT, C_ILLEGAL
    } class_t;

    localparam logic [4:0] TIMEOUT_LAST = 5'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [4:0]  wait_cnt_q, wait_cnt_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic        bus_err_q, bus_err_d;

    logic [5:0]  opcode;
    class_t      cls;

    logic        imem_req_o, dmem_rd_o, dmem_wr_o;

    // ------------------------------------------------------------------
    // Instruction classification from the held instruction. The halt
    // opcode is checked first so it wins even if moved into a class range.
    // ------------------------------------------------------------------
    assign opcode = ir_q[31:26];

    always_comb begin
        cls = C_ILLEGAL;
        if (opcode == HALT_OPCODE)  cls = C_HALT;
        else if (opcode == 6'd0)    cls = C_NOP;
        else if (opcode <= 6'd15)   cls = C_RTYPE;
        else if (opcode <= 6'd23)   cls = C_ITYPE;
        else if (opcode <= 6'd25)   cls = C_LOAD;
        else if (opcode <= 6'd27)   cls = C_STORE;
        else if (opcode == 6'd28)   cls = C_BEQ;
        else if (opcode == 6'd29)   cls = C_BNE;
        else if (opcode <= 6'd31)   cls = C_JMP;
    end

    // ------------------------------------------------------------------
    // State register (plus datapath/flag registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = wait_cnt_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_NOP:     state_d = S_FETCH;
                    C_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    C_ILLEGAL: begin
                        state_d   = S_FAULT;
                        illegal_d = 1'b1;
                    end
                    default:   state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_RTYPE, C_ITYPE: state_d = S_WB;
                    C_LOAD, C_STORE: begin
                        state_d    = S_MEM;
                        wait_cnt_d = '0;
                    end
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Ready is tested before the timeout so a ready arriving on
                // the last permitted cycle completes the access.
                if (bus.dmem_ready) begin
                    state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_FAULT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. FETCH is the reset state, so the fetch-side strobes are
    // qualified with reset_n to keep every output low while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_o  = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        dmem_rd_o   = 1'b0;
        dmem_wr_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_o = reset_n;
                ir_load    = reset_n & bus.imem_valid;
                pc_inc     = reset_n & bus.imem_valid;
            end
            S_EXEC: begin
                alu_src_imm = (cls == C_ITYPE) || (cls == C_LOAD) || (cls == C_STORE);
                pc_branch   = ((cls == C_BEQ) &&  alu_zero) ||
                              ((cls == C_BNE) && !alu_zero) ||
                               (cls == C_JMP);
            end
            S_MEM: begin
                dmem_rd_o = (cls == C_LOAD);
                dmem_wr_o = (cls == C_STORE);
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (cls == C_LOAD);
            end
            default: ;
        endcase
    end

    assign bus.imem_req = imem_req_o;
    assign bus.dmem_rd  = dmem_rd_o;
    assign bus.dmem_wr  = dmem_wr_o;

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign alu_op  = ir_q[31:26];
    assign ir      = ir_q;
    assign state   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_zero;
    logic        ir_load, pc_inc, pc_branch, alu_src_imm, rf_we, wb_sel;
    logic        halted, illegal, bus_err;
    logic [5:0]  alu_op;
    logic [31:0] ir;
    logic [2:0]  state;

    instr_sequencer_if bus_if ();

    instr_sequencer #(.MEM_TIMEOUT(16), .HALT_OPCODE(6'd63)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .alu_zero    (alu_zero),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .alu_op      (alu_op),
        .ir          (ir),
        .state       (state)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_EXEC = 3'd2, ST_MEM = 3'd3,
                           ST_HALT = 3'd5, ST_FAULT = 3'd6;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       zero;
        int         ready_at;   // MEM cycle on which dmem_ready rises, 0 = never
        int         exp_lat;    // clock edges until back in FETCH/HALT/FAULT
        logic [2:0] exp_state;
        int         exp_rfwe;
        logic       exp_wbsel;
        int         exp_br;
        int         exp_rd;
        int         exp_wr;
        logic       exp_exec;
        logic       exp_imm;
        logic       exp_halted;
        logic       exp_ill;
        logic       exp_berr;
        int         sticky;     // extra cycles to confirm a terminal state holds
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic [5:0] op, input logic z,
                                input int rdy, input int lat, input logic [2:0] st,
                                input int rfwe, input logic wbs, input int br,
                                input int rd, input int wr, input logic ex,
                                input logic imm, input logic h, input logic il,
                                input logic be, input int sticky);
        vec_t v;
        v.name = n; v.op = op; v.zero = z; v.ready_at = rdy; v.exp_lat = lat;
        v.exp_state = st; v.exp_rfwe = rfwe; v.exp_wbsel = wbs; v.exp_br = br;
        v.exp_rd = rd; v.exp_wr = wr; v.exp_exec = ex; v.exp_imm = imm;
        v.exp_halted = h; v.exp_ill = il; v.exp_berr = be; v.sticky = sticky;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus_if.imem_valid = 1'b0;
        bus_if.dmem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] word;
        int lat, mem_cyc, n_rfwe, n_br, n_rd, n_wr;
        logic wbs_seen, imm_seen;
        logic [5:0] op_seen;
        logic done;
        word = {v.op, 26'h2A5_5A5C};
        lat = 0; mem_cyc = 0; n_rfwe = 0; n_br = 0; n_rd = 0; n_wr = 0;
        wbs_seen = 1'b0; imm_seen = 1'b0; op_seen = '0; done = 1'b0;

        do_reset();
        alu_zero = v.zero;
        bus_if.instr = word;
        bus_if.imem_valid = 1'b1;
        #1;
        chk({v.name, " fetch_strobes"}, {61'd0, bus_if.imem_req, ir_load, pc_inc}, 64'h7);

        for (int c = 1; c <= 64 && !done; c++) begin
            @(posedge clk); #1;
            bus_if.imem_valid = 1'b0;
            bus_if.instr = 32'hFFFF_FFFF;   // must not be captured outside FETCH
            if (state == ST_MEM) mem_cyc++;
            bus_if.dmem_ready = (state == ST_MEM) && (v.ready_at != 0) && (mem_cyc == v.ready_at);
            #1;
            n_rfwe += int'(rf_we);
            n_br   += int'(pc_branch);
            n_rd   += int'(bus_if.dmem_rd);
            n_wr   += int'(bus_if.dmem_wr);
            if (rf_we) wbs_seen = wb_sel;
            if (state == ST_EXEC) begin
                op_seen  = alu_op;
                imm_seen = alu_src_imm;
            end
            if (state == ST_FETCH || state == ST_HALT || state == ST_FAULT) begin
                done = 1'b1;
                lat  = c;
            end
        end
        bus_if.dmem_ready = 1'b0;

        chk({v.name, " done_in_budget"}, 64'(done), 64'd1);
        chk({v.name, " latency"},  64'(lat),    64'(v.exp_lat));
        chk({v.name, " end_state"}, 64'(state), 64'(v.exp_state));
        chk({v.name, " rf_we_cnt"}, 64'(n_rfwe), 64'(v.exp_rfwe));
        if (v.exp_rfwe != 0) chk({v.name, " wb_sel"}, 64'(wbs_seen), 64'(v.exp_wbsel));
        chk({v.name, " branch_cnt"}, 64'(n_br), 64'(v.exp_br));
        chk({v.name, " dmem_rd_cnt"}, 64'(n_rd), 64'(v.exp_rd));
        chk({v.name, " dmem_wr_cnt"}, 64'(n_wr), 64'(v.exp_wr));
        if (v.exp_exec) begin
            chk({v.name, " alu_op"}, 64'(op_seen), 64'(v.op));
            chk({v.name, " alu_src_imm"}, 64'(imm_seen), 64'(v.exp_imm));
        end
        chk({v.name, " flags"}, {61'd0, halted, illegal, bus_err},
            {61'd0, v.exp_halted, v.exp_ill, v.exp_berr});
        chk({v.name, " imem_req"}, 64'(bus_if.imem_req), 64'(v.exp_state == ST_FETCH));
        chk({v.name, " ir"}, 64'(ir), 64'(word));

        for (int s = 0; s < v.sticky; s++) begin
            @(posedge clk); #1;
            bus_if.imem_valid = 1'b1;
            bus_if.dmem_ready = 1'b1;
            #1;
            chk({v.name, " sticky"},
                {52'd0, state, halted, illegal, bus_err, bus_if.imem_req, ir_load, rf_we,
                 bus_if.dmem_rd, bus_if.dmem_wr, pc_branch},
                {52'd0, v.exp_state, v.exp_halted, v.exp_ill, v.exp_berr, 6'd0});
        end
        bus_if.imem_valid = 1'b0;
        bus_if.dmem_ready = 1'b0;

        $display("vec %-10s op=%0d lat=%0d state=%0d rfwe=%0d br=%0d rd=%0d wr=%0d",
                 v.name, v.op, lat, state, n_rfwe, n_br, n_rd, n_wr);
    endtask

    function automatic logic [63:0] all_outs();
        return {6'd0, bus_if.imem_req, ir_load, pc_inc, pc_branch, alu_src_imm, rf_we, wb_sel,
                bus_if.dmem_rd, bus_if.dmem_wr, halted, illegal, bus_err, alu_op, ir, state};
    endfunction

    initial begin
        logic reached;
        reset_n = 1'b0;
        alu_zero = 1'b0;
        bus_if.instr = 32'h1400_0000;
        bus_if.imem_valid = 1'b1;    // outputs must stay low regardless while in reset
        bus_if.dmem_ready = 1'b0;

        //   name        op  z rdy lat state    rfwe wbs br rd  wr  ex imm h il be sticky
        add("rtype",     5, 0, 0,  4, ST_FETCH, 1,   0,  0, 0,  0,  1, 0, 0, 0, 0, 0);
        add("itype",    16, 0, 0,  4, ST_FETCH, 1,   0,  0, 0,  0,  1, 1, 0, 0, 0, 0);
        add("nop",       0, 0, 0,  2, ST_FETCH, 0,   0,  0, 0,  0,  0, 0, 0, 0, 0, 0);
        add("load_r3",  24, 0, 3,  7, ST_FETCH, 1,   1,  0, 3,  0,  1, 1, 0, 0, 0, 0);
        add("store_r1", 27, 0, 1,  4, ST_FETCH, 0,   0,  0, 0,  1,  1, 1, 0, 0, 0, 0);
        add("beq_z1",   28, 1, 0,  3, ST_FETCH, 0,   0,  1, 0,  0,  1, 0, 0, 0, 0, 0);
        add("beq_z0",   28, 0, 0,  3, ST_FETCH, 0,   0,  0, 0,  0,  1, 0, 0, 0, 0, 0);
        add("bne_z1",   29, 1, 0,  3, ST_FETCH, 0,   0,  0, 0,  0,  1, 0, 0, 0, 0, 0);
        add("bne_z0",   29, 0, 0,  3, ST_FETCH, 0,   0,  1, 0,  0,  1, 0, 0, 0, 0, 0);
        add("jmp30",    30, 0, 0,  3, ST_FETCH, 0,   0,  1, 0,  0,  1, 0, 0, 0, 0, 0);
        add("jmp31",    31, 1, 0,  3, ST_FETCH, 0,   0,  1, 0,  0,  1, 0, 0, 0, 0, 0);
        add("st_tmo",   26, 0, 0, 19, ST_FAULT, 0,   0,  0, 0, 16,  1, 1, 0, 0, 1, 8);
        add("st_r16",   26, 0, 16,19, ST_FETCH, 0,   0,  0, 0, 16,  1, 1, 0, 0, 0, 0);
        add("ld_r16",   25, 0, 16,20, ST_FETCH, 1,   1,  0, 16, 0,  1, 1, 0, 0, 0, 0);
        add("illegal40",40, 0, 0,  2, ST_FAULT, 0,   0,  0, 0,  0,  0, 0, 0, 1, 0, 8);
        add("illegal32",32, 0, 0,  2, ST_FAULT, 0,   0,  0, 0,  0,  0, 0, 0, 1, 0, 0);
        add("halt63",   63, 0, 0,  2, ST_HALT,  0,   0,  0, 0,  0,  0, 0, 1, 0, 0, 100);

        // Reset held: every output low, including imem_req in the FETCH state.
        #12;
        chk("reset_all_zero", all_outs(), 64'd0);
        @(posedge clk); #1;
        chk("reset_all_zero_2", all_outs(), 64'd0);
        reset_n = 1'b1;
        bus_if.imem_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_fetch", {61'd0, state, bus_if.imem_req} , {61'd0, ST_FETCH, 1'b1});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted mid-MEM: strobes drop at once and nothing follows.
        do_reset();
        bus_if.instr = {6'd24, 26'd0};
        bus_if.imem_valid = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 10 && !reached; c++) begin
            @(posedge clk); #1;
            bus_if.imem_valid = 1'b0;
            if (state == ST_MEM) reached = 1'b1;
        end
        chk("midmem_reached", 64'(reached), 64'd1);
        @(posedge clk); #1;
        chk("midmem_rd_before", 64'(bus_if.dmem_rd), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midmem_rst_outs", all_outs(), 64'd0);
        bus_if.dmem_ready = 1'b1;
        @(posedge clk); #1;
        chk("midmem_rst_hold", all_outs(), 64'd0);
        reset_n = 1'b1;
        bus_if.dmem_ready = 1'b0;
        #1;
        chk("midmem_resume", {61'd0, state, bus_if.imem_req}, {61'd0, ST_FETCH, 1'b1});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus_if.dmem_ready = 1'b1;
            #1;
            chk("midmem_no_strobe", {60'd0, rf_we, bus_if.dmem_rd, bus_if.dmem_wr, state == ST_FETCH},
                64'd1);
        end
        bus_if.dmem_ready = 1'b0;
        $display("seq midmem_reset done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of cycles spent in MEM waiting for dmem_ready.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 6'd63: the opcode that stops the sequencer.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port instr, input, 32 bits: the instruction word from instruction memory; opcode is instr[31:26].
REQ-006 The block SHALL have port imem_valid, input, 1 bit: instr is valid in this cycle.
REQ-007 The block SHALL have port dmem_ready, input, 1 bit: the data memory has completed the current read or write.
REQ-008 The block SHALL have port alu_zero, input, 1 bit: the ALU result-zero flag, valid in EXEC.
REQ-009 The block SHALL have outputs imem_req, ir_load, pc_inc, pc_branch, alu_src_imm, rf_we, wb_sel, dmem_rd, dmem_wr, halted, illegal and bus_err, each 1 bit, with the meanings given in Function.
REQ-010 The block SHALL have output alu_op, 6 bits: the opcode of the held instruction.
REQ-011 The block SHALL have output ir, 32 bits: the held instruction register, which feeds the code interpreter.
REQ-012 The block SHALL have output state, 3 bits: the current state, for debug.

Function
REQ-013 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
REQ-014 Instructions SHALL be classified from ir[31:26] as follows:
- 0 = NOP
- 1..15 = R-type
- 16..23 = I-type
- 24..25 = LOAD
- 26..27 = STORE
- 28 = BEQ
- 29 = BNE
- 30..31 = JMP
- HALT_OPCODE = HALT
- all others = illegal
REQ-015 In FETCH: imem_req=1. If imem_valid=1, then in that cycle ir_load=1 and pc_inc=1, ir<=instr at the clock edge, and the next state is DECODE. Otherwise the block SHALL stay in FETCH with ir unchanged.
REQ-016 From DECODE, the next state SHALL be:
- NOP -> FETCH
- HALT -> HALT
- illegal -> FAULT, with illegal=1 latched
- all other classes -> EXEC
DECODE always lasts exactly one cycle.
REQ-017 In EXEC: alu_op=ir[31:26], and alu_src_imm=1 for the I-type, LOAD and STORE classes, 0 otherwise.
REQ-018 The next state from EXEC SHALL be:
- R-type and I-type -> WB
- LOAD and STORE -> MEM
- branch and jump -> FETCH
REQ-019 In EXEC, pc_branch=1 for one cycle when any of these holds:
- BEQ with alu_zero=1
- BNE with alu_zero=0
- JMP, regardless of alu_zero
pc_branch SHALL be 0 in every other state or case.
REQ-020 In MEM: dmem_rd=1 for LOAD, dmem_wr=1 for STORE, held every cycle until dmem_ready=1. On ready, LOAD goes to WB and STORE goes to FETCH.
REQ-021 A 5-bit wait counter SHALL clear on entry to MEM and increment each MEM cycle without dmem_ready. If it reaches MEM_TIMEOUT-1 with dmem_ready still 0, the next state is FAULT with bus_err=1 latched.
REQ-022 If dmem_ready=1 on the same cycle the timeout is reached, the ready SHALL win and no fault occurs.
REQ-023 In WB: rf_we=1 for exactly one cycle, wb_sel=1 for LOAD and 0 otherwise; next state FETCH.
REQ-024 HALT SHALL drive halted=1, and FAULT SHALL hold illegal or bus_err. Both states are sticky until reset, and imem_req=0 in both.
REQ-025 All control outputs SHALL be Moore functions of state and ir, except ir_load and pc_inc, which also depend on imem_valid. Control outputs SHALL be 0 in every state where they are not specified above.
REQ-026 Instruction latency SHALL be, counted from the cycle imem_valid is seen:
- R-type and I-type: 4 cycles
- BEQ, BNE and JMP: 3 cycles
- NOP: 2 cycles
- LOAD: 4 cycles plus memory wait
- STORE: 3 cycles plus memory wait
REQ-027 imem_valid SHALL be ignored outside FETCH, and dmem_ready SHALL be ignored outside MEM.

Reset
REQ-028 While reset_n=0, asynchronously: state=FETCH, ir=0, wait counter=0, and halted, illegal and bus_err all 0.
REQ-029 While reset_n=0, all outputs SHALL be 0, including imem_req.
REQ-030 Reset asserted in any state, including mid-MEM, SHALL abort the current instruction, and no rf_we or dmem strobe SHALL be produced afterwards.
REQ-031 On the first rising edge after reset_n deasserts, the block SHALL be in FETCH with imem_req=1.

Verification
REQ-032 R-type: instr opcode 5 with imem_valid=1 -> states FETCH, DECODE, EXEC, WB, FETCH; alu_op=5 in EXEC; a single rf_we pulse with wb_sel=0.
REQ-033 LOAD: opcode 24 with dmem_ready asserted on the 3rd MEM cycle -> dmem_rd high for 3 cycles; WB with wb_sel=1 and rf_we=1; then FETCH.
REQ-034 BEQ and BNE: opcode 28 with alu_zero=1 -> one pc_branch pulse. Opcode 29 with alu_zero=1 -> pc_branch stays 0. Both return to FETCH after EXEC.
REQ-035 Timeout: STORE opcode 26 with dmem_ready held 0 -> FAULT after 16 MEM cycles, bus_err=1, imem_req=0 thereafter. With dmem_ready first asserted on the 16th MEM cycle -> no fault.
REQ-036 Opcode 40 -> FAULT with illegal=1. Opcode 63 -> HALT with halted=1, sticky over 100 cycles.
REQ-037 Mid-operation reset: reset_n pulsed low during MEM -> dmem_rd and dmem_wr drop immediately, all outputs 0; after release the block resumes in FETCH.
